// File: rtl/regfile_wb_queue_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_queue_if
// Writeback request bundle between the commit stage (master) and the
// register-file write queue (slave).
//   wr_valid  [1:0]      per-port request, bit0 older than bit1
//   wr_addr0/1 [4:0]     register index per port
//   wr_data0/1 [WIDTH]   write data per port
//   wr_ready             queue can take both ports this cycle
// ----------------------------------------------------------------------------
interface regfile_wb_queue_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       wr_valid;
  logic [4:0]       wr_addr0;
  logic [4:0]       wr_addr1;
  logic [WIDTH-1:0] wr_data0;
  logic [WIDTH-1:0] wr_data1;
  logic             wr_ready;

  modport master (
    output wr_valid, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output wr_ready
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// ----------------------------------------------------------------------------
// regfile_wb_queue
// Write-side front end of the 32-entry 3R/1W register-file RAM. Up to two
// writebacks per cycle are queued in order and drained one per cycle into the
// RAM write port. All three read ports are bypassed against pending entries.
//   clk, rst                async active-high reset
//   wr_if (slave)           dual writeback request + wr_ready
//   ram_we/ram_addrw/ram_din   RAM write port (head of queue)
//   rd_addr0..2             read indices (also address the RAM read ports)
//   ram_dout0..2            RAM read data, combinational from rd_addr*
//   rd_data0..2             bypassed read data
// ----------------------------------------------------------------------------
module regfile_wb_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  regfile_wb_queue_if.slave wr_if,
  output logic             ram_we,
  output logic [4:0]       ram_addrw,
  output logic [WIDTH-1:0] ram_din,
  input  logic [4:0]       rd_addr0,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  input  logic [WIDTH-1:0] ram_dout0,
  input  logic [WIDTH-1:0] ram_dout1,
  input  logic [WIDTH-1:0] ram_dout2,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Queue storage (data path, not reset) and control state
  logic [4:0]       r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_ready;
  logic             w_push0;
  logic             w_push1;
  logic             w_pop;
  logic [PW-1:0]    w_tail1;
  logic [CW-1:0]    w_npush;

  logic [4:0]       w_rd_addr [3];
  logic [WIDTH-1:0] w_ram_dout [3];
  logic [WIDTH-1:0] w_rd_data [3];

  // Room for two entries is judged on the registered count, so a dual push
  // can never overflow even though a pop happens on the same edge.
  assign w_ready = (r_count <= CW'(DEPTH - 2));
  assign wr_if.wr_ready = w_ready;

  // Writes to r0 are architecturally meaningless and never queued.
  assign w_push0 = w_ready & wr_if.wr_valid[0] & (wr_if.wr_addr0 != 5'd0);
  assign w_push1 = w_ready & wr_if.wr_valid[1] & (wr_if.wr_addr1 != 5'd0);
  assign w_pop   = (r_count != '0);

  // Port1 lands behind port0 when both push, otherwise directly at tail.
  assign w_tail1 = r_tail + PW'(w_push0);
  assign w_npush = CW'(w_push0) + CW'(w_push1);

  // ---- queue control state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_npush);
      r_count <= r_count + w_npush - CW'(w_pop);
    end
  end

  // ---- queue storage ----
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_addr[r_tail] <= wr_if.wr_addr0;
      r_data[r_tail] <= wr_if.wr_data0;
    end
    if (w_push1) begin
      r_addr[w_tail1] <= wr_if.wr_addr1;
      r_data[w_tail1] <= wr_if.wr_data1;
    end
  end

  // RAM write port presents the head entry; address/data forced to zero when
  // idle so nothing stale or uninitialised leaks onto the bus.
  assign ram_we    = w_pop;
  assign ram_addrw = w_pop ? r_addr[r_head] : 5'd0;
  assign ram_din   = w_pop ? r_data[r_head] : '0;

  assign w_rd_addr[0]  = rd_addr0;
  assign w_rd_addr[1]  = rd_addr1;
  assign w_rd_addr[2]  = rd_addr2;
  assign w_ram_dout[0] = ram_dout0;
  assign w_ram_dout[1] = ram_dout1;
  assign w_ram_dout[2] = ram_dout2;

  // Bypass: walk pending entries oldest to newest so the last match (newest)
  // wins. The head entry being written this cycle is still included because
  // the RAM only reflects it after the edge.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_rd_data[k] = w_ram_dout[k];
      for (int i = 0; i < DEPTH; i++) begin
        if (i < int'(r_count)) begin
          if (r_addr[r_head + PW'(i)] == w_rd_addr[k]) begin
            w_rd_data[k] = r_data[r_head + PW'(i)];
          end
        end
      end
      if (w_rd_addr[k] == 5'd0) begin
        w_rd_data[k] = '0;
      end
    end
  end

  assign rd_data0 = w_rd_data[0];
  assign rd_data1 = w_rd_data[1];
  assign rd_data2 = w_rd_data[2];

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;
  logic        clk;
  logic        rst;
  logic        ram_we;
  logic [4:0]  ram_addrw;
  logic [31:0] ram_din;
  logic [4:0]  rd_addr0, rd_addr1, rd_addr2;
  logic [31:0] ram_dout0, ram_dout1, ram_dout2;
  logic [31:0] rd_data0, rd_data1, rd_data2;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [32] = '{default: 32'd0};
  logic [36:0] wlog [$];

  regfile_wb_queue_if #(.WIDTH(32)) wif ();

  regfile_wb_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_if(wif),
    .ram_we(ram_we), .ram_addrw(ram_addrw), .ram_din(ram_din),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: combinational reads, write on clock edge, logs every write.
  assign ram_dout0 = mem[rd_addr0];
  assign ram_dout1 = mem[rd_addr1];
  assign ram_dout2 = mem[rd_addr2];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addrw] <= ram_din;
      wlog.push_back({ram_addrw, ram_din});
    end
  end

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    wif.wr_valid = v;
    wif.wr_addr0 = a0;
    wif.wr_data0 = d0;
    wif.wr_addr1 = a1;
    wif.wr_data1 = d1;
  endtask

  logic [31:0] arch [32];
  int          mcount;
  int          base;
  logic [1:0]  rv;
  logic [4:0]  ra0, ra1;
  logic [31:0] rdd0, rdd1;

  initial begin
    rst = 1'b1;
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rd_addr0 = 5'd0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    check("reset_we", ram_we, 0);
    check("reset_ready", wif.wr_ready, 1);
    check("reset_addrw", ram_addrw, 0);
    check("reset_din", ram_din, 0);
    tick();
    tick();
    rst = 1'b0;

    // Single write
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rd_addr1 = 5'd5;
    #1;
    check("single_we", ram_we, 1);
    check("single_addrw", ram_addrw, 5);
    check("single_din", ram_din, 32'hDEADBEEF);
    check("single_bypass", rd_data1, 32'hDEADBEEF);
    tick();
    #1;
    check("single_idle_we", ram_we, 0);
    check("single_ram_rd", rd_data1, 32'hDEADBEEF);

    // r0 dropped, r3 written
    drive(2'b11, 5'd0, 32'hAAAA_AAAA, 5'd3, 32'h33);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rd_addr0 = 5'd0;
    #1;
    check("r0_addrw", ram_addrw, 3);
    check("r0_din", ram_din, 32'h33);
    check("r0_read_zero", rd_data0, 0);
    tick();
    rd_addr1 = 5'd3;
    #1;
    check("r0_single_entry", ram_we, 0);
    check("r3_ram_rd", rd_data1, 32'h33);
    check("r0_mem_untouched", mem[0], 0);

    // Dual same-address
    drive(2'b11, 5'd7, 32'h1, 5'd7, 32'h2);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rd_addr2 = 5'd7;
    #1;
    check("dual_first_din", {ram_addrw, ram_din}, {5'd7, 32'h1});
    check("dual_bypass_newest", rd_data2, 32'h2);
    tick();
    #1;
    check("dual_second_din", {ram_addrw, ram_din}, {5'd7, 32'h2});
    check("dual_bypass_head", rd_data2, 32'h2);
    tick();
    #1;
    check("dual_idle_we", ram_we, 0);
    check("dual_ram_final", rd_data2, 32'h2);

    // Fill / backpressure
    base = wlog.size();
    drive(2'b11, 5'd10, 32'hA0, 5'd11, 32'hB1);
    tick();
    check("fill_ready_cnt2", wif.wr_ready, 1);
    drive(2'b11, 5'd12, 32'hC2, 5'd13, 32'hD3);
    tick();
    #1;
    check("fill_ready_cnt3", wif.wr_ready, 0);
    check("fill_head11", ram_addrw, 11);
    drive(2'b11, 5'd14, 32'hE4, 5'd15, 32'hF5);
    tick();
    rd_addr0 = 5'd13;
    #1;
    check("fill_ready_back", wif.wr_ready, 1);
    check("fill_head12", ram_addrw, 12);
    check("fill_bypass13", rd_data0, 32'hD3);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("fill_ready_cnt3b", wif.wr_ready, 0);
    check("fill_head13", ram_addrw, 13);
    tick(); tick(); tick();
    #1;
    check("fill_drained", ram_we, 0);
    check("fill_log_len", wlog.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < wlog.size())
        check($sformatf("fill_order%0d", i), wlog[base + i],
              {5'(10 + i), 32'hA0 + 32'(i) * 32'h11});
    end

    // Reset mid-drain with count=3
    drive(2'b11, 5'd20, 32'h20, 5'd21, 32'h21);
    tick();
    drive(2'b11, 5'd22, 32'h22, 5'd23, 32'h23);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check("rst_pre_we", ram_we, 1);
    base = wlog.size();
    rst = 1'b1;
    #1;
    check("rst_we", ram_we, 0);
    check("rst_ready", wif.wr_ready, 1);
    check("rst_addrw", ram_addrw, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    rd_addr0 = 5'd22;
    #1;
    check("rst_no_writes", wlog.size() - base, 0);
    check("rst_discarded_rd", rd_data0, 0);

    // Randomised run against an architectural register model
    for (int i = 0; i < 32; i++) arch[i] = mem[i];
    mcount = 0;
    for (int c = 0; c < 2000; c++) begin
      rv   = 2'($urandom_range(0, 3));
      ra0  = 5'($urandom_range(0, 7));
      ra1  = 5'($urandom_range(0, 7));
      rdd0 = $urandom;
      rdd1 = $urandom;
      drive(rv, ra0, rdd0, ra1, rdd1);
      rd_addr0 = 5'($urandom_range(0, 7));
      rd_addr1 = 5'($urandom_range(0, 7));
      rd_addr2 = 5'($urandom_range(0, 31));
      #1;
      check("rand_rd0", rd_data0, (rd_addr0 == 0) ? 32'd0 : arch[rd_addr0]);
      check("rand_rd1", rd_data1, (rd_addr1 == 0) ? 32'd0 : arch[rd_addr1]);
      check("rand_rd2", rd_data2, (rd_addr2 == 0) ? 32'd0 : arch[rd_addr2]);
      check("rand_ready", wif.wr_ready, (mcount <= 2) ? 1 : 0);
      check("rand_we", ram_we, (mcount != 0) ? 1 : 0);
      begin
        int pushes;
        pushes = 0;
        if (mcount <= 2) begin
          if (rv[0] && ra0 != 0) begin arch[ra0] = rdd0; pushes++; end
          if (rv[1] && ra1 != 0) begin arch[ra1] = rdd1; pushes++; end
        end
        mcount = mcount + pushes - ((mcount != 0) ? 1 : 0);
      end
      tick();
    end
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    tick(); tick(); tick(); tick();
    #1;
    check("rand_drained", ram_we, 0);
    for (int i = 1; i < 8; i++)
      check($sformatf("rand_final_r%0d", i), mem[i], arch[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
